// File: rtl/delay_skid_if.sv
// Control bundle for delay_skid: the single rising-edge clock and the
// asynchronous active-low reset, carried together as one port.
interface delay_skid_if;
  logic clk;
  logic rst_n;

  modport dut (
    input clk,
    input rst_n
  );
endinterface

// File: rtl/delay_skid.sv
// Two-entry ready/valid skid stage behind the delay line. Upstream ready is
// decoded from registered state only, so out_ready never reaches in_ready.
module delay_skid #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  delay_skid_if.dut              ctrl,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [CNT_WIDTH-1:0]   stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [WIDTH-1:0]     main_q;
  logic [WIDTH-1:0]     skid_q;
  logic [CNT_WIDTH-1:0] stall_q;

  logic accept_in;
  logic accept_out;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;
  logic stall_inc;

  assign accept_in  = in_valid & in_ready;
  assign accept_out = out_valid & out_ready;
  assign stall_inc  = out_valid & ~out_ready & ~flush & (stall_q != {CNT_WIDTH{1'b1}});

  assign out_data    = main_q;
  assign stall_count = stall_q;

  always_ff @(posedge ctrl.clk or negedge ctrl.rst_n) begin
    if (!ctrl.rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Data registers are left untouched by flush; only the state is squashed.
  always_ff @(posedge ctrl.clk or negedge ctrl.rst_n) begin
    if (!ctrl.rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_data;
      end
    end
  end

  always_ff @(posedge ctrl.clk or negedge ctrl.rst_n) begin
    if (!ctrl.rst_n) begin
      stall_q <= '0;
    end else if (stall_inc) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    in_ready       = 1'b1;
    out_valid      = 1'b0;
    occupancy      = 2'd0;

    unique case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept_in) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept_in && accept_out) begin
            load_main_in = 1'b1;
          end else if (accept_in) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (accept_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so the skid entry is the only candidate.
          if (accept_out) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_skid.sv
// Directed-vector bench for delay_skid with a 2-bit stall counter so that
// saturation is reachable in a handful of cycles.
module tb_delay_skid;

  localparam int WIDTH     = 4;
  localparam int CNT_WIDTH = 2;

  delay_skid_if ctrl_if ();

  logic                 flush;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;
  logic [1:0]           occupancy;
  logic [CNT_WIDTH-1:0] stall_count;

  int vector_count;
  int miscompare_count;

  delay_skid #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .ctrl        (ctrl_if),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .occupancy   (occupancy),
    .stall_count (stall_count)
  );

  initial ctrl_if.clk = 1'b0;
  always #5 ctrl_if.clk = ~ctrl_if.clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle 1 ns past the edge.
  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] id,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge ctrl_if.clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic ir, input logic ov,
                            input logic [1:0] occ, input logic [CNT_WIDTH-1:0] sc);
    checkOutput({tag, ".in_ready"},    32'(in_ready),    32'(ir));
    checkOutput({tag, ".out_valid"},   32'(out_valid),   32'(ov));
    checkOutput({tag, ".occupancy"},   32'(occupancy),   32'(occ));
    checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'(sc));
  endtask

  task automatic pulseReset();
    ctrl_if.rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    ctrl_if.rst_n = 1'b1;
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    ctrl_if.rst_n    = 1'b0;
    flush            = 1'b0;
    in_valid         = 1'b0;
    in_data          = '0;
    out_ready        = 1'b0;

    // Reset and pass-through
    pulseReset();
    checkState("reset", 1'b1, 1'b0, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, WIDTH'(i), 1'b1, 1'b0);
      checkState($sformatf("pass%0d", i), 1'b1, 1'b1, 2'd1, 2'd0);
      checkOutput($sformatf("pass%0d.data", i), 32'(out_data), 32'(i));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkState("pass_drain", 1'b1, 1'b0, 2'd0, 2'd0);

    // Backpressure fill: 5 presented, out_ready drops, 6 lands in skid
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
    checkOutput("bp.first", 32'(out_data), 32'd5);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0);
    checkState("bp_full", 1'b0, 1'b1, 2'd2, 2'd1);
    checkOutput("bp_full.data", 32'(out_data), 32'd5);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
    checkState("bp_hold", 1'b0, 1'b1, 2'd2, 2'd2);
    checkOutput("bp_hold.data", 32'(out_data), 32'd5);
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0);
    checkState("bp_pop6", 1'b1, 1'b1, 2'd1, 2'd2);
    checkOutput("bp_pop6.data", 32'(out_data), 32'd6);
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0);
    checkOutput("bp_pop7.data", 32'(out_data), 32'd7);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkState("bp_drain", 1'b1, 1'b0, 2'd0, 2'd2);

    // Simultaneous accept in ONE
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
    checkOutput("sim.main3", 32'(out_data), 32'd3);
    applyStimulus(1'b1, 4'd4, 1'b1, 1'b0);
    checkState("sim", 1'b1, 1'b1, 2'd1, 2'd2);
    checkOutput("sim.main4", 32'(out_data), 32'd4);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush priority from FULL with 9/10; stall saturates at 3 on the way
    applyStimulus(1'b1, 4'd9, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0, 1'b0);
    checkState("fl_full", 1'b0, 1'b1, 2'd2, 2'd3);
    applyStimulus(1'b1, 4'd11, 1'b1, 1'b1);
    checkState("flush", 1'b1, 1'b0, 2'd0, 2'd3);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkState("fl_after", 1'b1, 1'b0, 2'd0, 2'd3);
    applyStimulus(1'b1, 4'd12, 1'b1, 1'b0);
    checkOutput("fl_next.data", 32'(out_data), 32'd12);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Counter saturation from a clean reset
    pulseReset();
    applyStimulus(1'b1, 4'd1, 1'b1, 1'b0);
    checkState("sat_start", 1'b1, 1'b1, 2'd1, 2'd0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("sat%0d", i), 32'(stall_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkState("sat_flush", 1'b1, 1'b0, 2'd0, 2'd3);

    // Async reset between edges while FULL
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
    checkState("ar_full", 1'b0, 1'b1, 2'd2, 2'd3);
    #2;
    ctrl_if.rst_n = 1'b0;
    #1;
    checkState("ar_async", 1'b1, 1'b0, 2'd0, 2'd0);
    checkOutput("ar_async.main", 32'(out_data), 32'd0);
    #1;
    ctrl_if.rst_n = 1'b1;
    applyStimulus(1'b1, 4'hA, 1'b1, 1'b0);
    checkState("ar_first", 1'b1, 1'b1, 2'd1, 2'd0);
    checkOutput("ar_first.data", 32'(out_data), 32'hA);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkState("ar_drain", 1'b1, 1'b0, 2'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
